// File: rtl/spi_reg_responder.sv
// SPI target exposing a 128-byte register space. The first byte of a frame
// is a command (bit 7 = read, bits 6:0 = start address); the following bytes
// are data, read or written with address auto-increment. All SPI inputs are
// synchronised to CLK, and edges are taken from the synchronised copies.
module spi_reg_responder #(
  parameter bit         CPOL   = 1'b0,
  parameter logic [7:0] STATUS = 8'h5A
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       nSS,
  output logic       MISO,
  output logic       MISO_OE,
  output logic [6:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  // With CPOL=1 the clock is inverted so everything below sees mode 0.
  logic sck_in;
  assign sck_in = SCK ^ CPOL;

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic nss_meta_q, nss_sync_q, nss_prev_q;

  // Two-flop synchronisers plus one history flop for edge detection.
  // nSS copies reset low so a select held low across reset is not taken
  // as a frame start; a fresh falling edge is required.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      nss_meta_q  <= 1'b0;
      nss_sync_q  <= 1'b0;
      nss_prev_q  <= 1'b0;
    end else begin
      sck_meta_q  <= sck_in;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
      nss_meta_q  <= nSS;
      nss_sync_q  <= nss_meta_q;
      nss_prev_q  <= nss_sync_q;
    end
  end

  logic sck_rise, sck_fall, nss_rise, nss_fall;
  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign nss_rise = nss_sync_q & ~nss_prev_q;
  assign nss_fall = ~nss_sync_q & nss_prev_q;

  logic [1:0] state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       rdld_q, rdld_d;   // REG_RDATA is valid this cycle: load tx
  logic       bend_q, bend_d;   // next falling SCK closes a byte: no shift

  logic [7:0] byte_c;
  assign byte_c = {rx_q[6:0], mosi_sync_q};

  // Frame FSM, shift registers and register-bus strobes.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    rdld_d   = re_q;
    bend_d   = bend_q;

    // A write strobe just issued advances the address one cycle later.
    if (we_q) addr_d = addr_q + 7'd1;
    if (rdld_q) tx_d = REG_RDATA;

    if (nss_rise) begin
      // End of frame or abort: a partial byte is simply dropped.
      state_d  = ST_IDLE;
      bitcnt_d = 3'd0;
      oe_d     = 1'b0;
      miso_d   = 1'b0;
      bend_d   = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (nss_fall) begin
        state_d  = ST_CMD;
        tx_d     = STATUS;
        bitcnt_d = 3'd0;
        oe_d     = 1'b1;
        miso_d   = STATUS[7];
        bend_d   = 1'b0;
      end
    end else if (sck_rise) begin
      rx_d     = byte_c;
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        bend_d = 1'b1;
        case (state_q)
          ST_CMD: begin
            addr_d = byte_c[6:0];
            if (byte_c[7]) begin
              state_d = ST_RD;
              re_d    = 1'b1;
            end else begin
              state_d = ST_WR;
            end
          end
          ST_RD: begin
            addr_d = addr_q + 7'd1;
            re_d   = 1'b1;
          end
          default: begin
            wdata_d = byte_c;
            we_d    = 1'b1;
          end
        endcase
      end
    end else if (sck_fall) begin
      if (bend_q) begin
        miso_d = tx_q[7];
        bend_d = 1'b0;
      end else begin
        tx_d   = {tx_q[6:0], 1'b0};
        miso_d = tx_q[6];
      end
    end
  end

  // State registers; every output returns to zero on reset.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      rx_q     <= 8'd0;
      tx_q     <= 8'd0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      addr_q   <= 7'd0;
      wdata_q  <= 8'd0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rdld_q   <= 1'b0;
      bend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      rdld_q   <= rdld_d;
      bend_q   <= bend_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_OE   = oe_q;
  assign REG_ADDR  = addr_q;
  assign REG_WDATA = wdata_q;
  assign REG_WE    = we_q;
  assign REG_RE    = re_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: a bit-banged SPI master drives a CPOL=0 and a
// CPOL=1 instance in parallel, each with its own register memory. Results
// are compared against a frame-level reference model of the register space.
module tb_spi_reg_responder;
  localparam int         HALF   = 8;
  localparam logic [7:0] STATUS = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst = 1'b0, sck = 1'b0, mosi = 1'b0, nss = 1'b1;
  logic sck1;
  assign sck1 = ~sck;

  logic       miso0, oe0, we0, re0, miso1, oe1, we1, re1;
  logic [6:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [7:0] rdata0 = 8'd0, rdata1 = 8'd0;

  spi_reg_responder #(.CPOL(1'b0), .STATUS(STATUS)) dut0 (
    .CLK(clk), .nRESET(nrst), .SCK(sck), .MOSI(mosi), .nSS(nss),
    .MISO(miso0), .MISO_OE(oe0), .REG_ADDR(addr0), .REG_WDATA(wdata0),
    .REG_WE(we0), .REG_RE(re0), .REG_RDATA(rdata0));

  spi_reg_responder #(.CPOL(1'b1), .STATUS(STATUS)) dut1 (
    .CLK(clk), .nRESET(nrst), .SCK(sck1), .MOSI(mosi), .nSS(nss),
    .MISO(miso1), .MISO_OE(oe1), .REG_ADDR(addr1), .REG_WDATA(wdata1),
    .REG_WE(we1), .REG_RE(re1), .REG_RDATA(rdata1));

  // Register memories with a registered read port and event logs.
  logic [7:0]  mem0 [128];
  logic [7:0]  mem1 [128];
  logic        ini_we = 1'b0;
  logic [6:0]  ini_a = 7'd0;
  logic [7:0]  ini_d = 8'd0;
  logic [14:0] wq0[$], wq1[$];
  logic [6:0]  rq0[$], rq1[$];

  always @(posedge clk) begin
    if (ini_we) begin
      mem0[ini_a] <= ini_d;
      mem1[ini_a] <= ini_d;
    end else begin
      if (we0) mem0[addr0] <= wdata0;
      if (we1) mem1[addr1] <= wdata1;
    end
    if (re0) rdata0 <= mem0[addr0];
    if (re1) rdata1 <= mem1[addr1];
    if (we0) wq0.push_back({addr0, wdata0});
    if (we1) wq1.push_back({addr1, wdata1});
    if (re0) rq0.push_back(addr0);
    if (re1) rq1.push_back(addr1);
  end

  int         vectors = 0, miscompares = 0;
  logic [7:0] ref_mem [128];
  logic [7:0] fb [16];
  logic [7:0] got0[$], got1[$];
  int         wi[2], ri[2], gi[2];

  function automatic int wsz(int k); return k ? wq1.size() : wq0.size(); endfunction
  function automatic int rsz(int k); return k ? rq1.size() : rq0.size(); endfunction
  function automatic int gsz(int k); return k ? got1.size() : got0.size(); endfunction
  function automatic logic [14:0] wat(int k, int i); return k ? wq1[i] : wq0[i]; endfunction
  function automatic logic [6:0] rat(int k, int i); return k ? rq1[i] : rq0[i]; endfunction
  function automatic logic [7:0] gat(int k, int i); return k ? got1[i] : got0[i]; endfunction
  function automatic logic [17:0] outs(int k);
    return k ? {miso1, oe1, we1, re1, addr1, wdata1} : {miso0, oe0, we0, re0, addr0, wdata0};
  endfunction
  function automatic logic [6:0] addr_of(int k); return k ? addr1 : addr0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    ini_we = 1'b1; ini_a = a; ini_d = d;
    @(negedge clk);
    ini_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Master: sends nbytes of fb, stopping before bit number cut (cut<0: full
  // frame). At the cut the frame is either aborted by nSS or by reset.
  task automatic spi_frame(input int nbytes, input int cut, input bit do_rst);
    logic [7:0] r0, r1;
    int  nbit;
    bit  stop;
    nbit = 0; stop = 1'b0; r0 = 8'd0; r1 = 8'd0;
    @(negedge clk);
    nss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbytes && !stop; i++) begin
      for (int b = 7; b >= 0 && !stop; b--) begin
        if (cut >= 0 && nbit == cut) begin
          stop = 1'b1;
        end else begin
          mosi = fb[i][b];
          repeat (HALF) @(negedge clk);
          r0 = {r0[6:0], miso0};
          r1 = {r1[6:0], miso1};
          sck = 1'b1;
          repeat (HALF) @(negedge clk);
          sck = 1'b0;
          nbit++;
        end
      end
      if (!stop) begin
        got0.push_back(r0);
        got1.push_back(r1);
      end
    end
    if (stop && do_rst) begin
      nrst = 1'b0;
      #1;
      chk("rst_mid_outs0", outs(0), 0);
      chk("rst_mid_outs1", outs(1), 0);
      repeat (3) @(negedge clk);
      nss = 1'b1; mosi = 1'b0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (8) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
      nss = 1'b1;
      if (stop) begin
        repeat (3) @(negedge clk);
        chk("abort_oe_miso0", {oe0, miso0}, 0);
        chk("abort_oe_miso1", {oe1, miso1}, 0);
      end
      repeat (12) @(negedge clk);
    end
  endtask

  // Frame-level expectations from the register-space rules.
  task automatic check_frame(input int n);
    logic [7:0] cmd;
    logic [6:0] a, av;
    int cnt;
    cmd = fb[0];
    a = cmd[6:0];
    for (int k = 0; k < 2; k++) begin
      chk("status_byte", gat(k, gi[k]), STATUS);
      if (cmd[7]) begin
        for (int i = 1; i < n; i++) begin
          av = a + 7'(i - 1);
          chk("rd_miso", gat(k, gi[k] + i), ref_mem[av]);
        end
        cnt = rsz(k) - ri[k];
        chk("re_count_ok", (cnt == n - 1 || cnt == n), 1);
        for (int j = 0; j < n - 1 && j < cnt; j++) begin
          av = a + 7'(j);
          chk("re_addr", rat(k, ri[k] + j), av);
        end
        chk("rd_no_we", wsz(k) - wi[k], 0);
        ri[k] = rsz(k);
        wi[k] = wsz(k);
      end else begin
        cnt = wsz(k) - wi[k];
        chk("we_count", cnt, n - 1);
        for (int j = 0; j < n - 1 && j < cnt; j++) begin
          av = a + 7'(j);
          chk("we_event", wat(k, wi[k] + j), {av, fb[j + 1]});
        end
        chk("wr_no_re", rsz(k) - ri[k], 0);
        av = a + 7'(n - 1);
        chk("addr_after_wr", addr_of(k), av);
        wi[k] = wsz(k);
        ri[k] = rsz(k);
      end
      gi[k] = gsz(k);
    end
    if (!cmd[7])
      for (int i = 1; i < n; i++) ref_mem[a + 7'(i - 1)] = fb[i];
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin wi[k] = 0; ri[k] = 0; gi[k] = 0; end
    #1;
    chk("reset_outs0", outs(0), 0);
    chk("reset_outs1", outs(1), 0);
    repeat (4) @(negedge clk);
    nrst = 1'b1;
    for (int a = 0; a < 128; a++) poke(7'(a), 8'($urandom));
    repeat (4) @(negedge clk);
    chk("idle_oe0", oe0, 0);
    chk("idle_oe1", oe1, 0);

    // Plain write frame.
    fb[0] = 8'h05; fb[1] = 8'h3C; fb[2] = 8'hC3;
    spi_frame(3, -1, 1'b0);
    check_frame(3);

    // Read frame from preset registers.
    poke(7'h10, 8'h11);
    poke(7'h11, 8'h22);
    fb[0] = 8'h90; fb[1] = 8'h00; fb[2] = 8'h00;
    spi_frame(3, -1, 1'b0);
    check_frame(3);

    // Write across the top of the address space.
    fb[0] = 8'h7F; fb[1] = 8'hD1; fb[2] = 8'hE2;
    spi_frame(3, -1, 1'b0);
    check_frame(3);

    // Abort 5 bits into the first data byte of a write.
    fb[0] = 8'h20; fb[1] = 8'hAB;
    spi_frame(2, 13, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("abort_status", gat(k, gi[k]), STATUS);
      chk("abort_no_we", wsz(k) - wi[k], 0);
      chk("abort_no_re", rsz(k) - ri[k], 0);
      chk("abort_addr_held", addr_of(k), 7'h20);
      gi[k] = gsz(k);
    end
    fb[0] = 8'hA0; fb[1] = 8'h00; fb[2] = 8'h00;
    spi_frame(3, -1, 1'b0);
    check_frame(3);

    // Randomised frames, reads and writes mixed.
    for (int f = 0; f < 8; f++) begin
      n = int'($urandom_range(2, 5));
      for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
      spi_frame(n, -1, 1'b0);
      check_frame(n);
    end

    // Reset in the middle of a data byte, then a normal frame.
    fb[0] = 8'h05; fb[1] = 8'h3C; fb[2] = 8'hC3;
    spi_frame(3, 11, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("rst_no_we", wsz(k) - wi[k], 0);
      wi[k] = wsz(k); ri[k] = rsz(k); gi[k] = gsz(k);
    end
    spi_frame(3, -1, 1'b0);
    check_frame(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
